// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter using shift-and-add-3
//               (double dabble), one shift per clock, with start/busy/done
//               handshake and overflow detection. Optional leading-zero
//               blanking output is enabled by defining BIN2BCD_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int                 c_cnt_w    = $clog2(BIN_W + 1);
    localparam int                 c_bcd_w    = 4 * DIGITS;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BIN_W-1:0]     r_shift;
    logic [c_bcd_w-1:0]   r_scratch;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf;
    logic [c_bcd_w-1:0]   w_adj;
    logic                 w_carry;
    logic [c_bcd_w-1:0]   w_scratch_sh;
    logic [BIN_W-1:0]     w_shift_sh;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and busy decode; busy spans LOAD..FIN so it falls as done rises
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_one) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Add 3 to every digit >= 5 (per-digit, no inter-digit carry)
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // {carry, scratch, shift} shifted left by one
    assign w_carry      = w_adj[c_bcd_w-1];
    assign w_scratch_sh = {w_adj[c_bcd_w-2:0], r_shift[BIN_W-1]};
    assign w_shift_sh   = {r_shift[BIN_W-2:0], 1'b0};

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] c_blank_rst = ~DIGITS'(1);

    logic [DIGITS-1:0] w_blank;
    logic              w_hi_zero;

    // Digit k is blank when it and every more significant digit are zero
    always_comb begin
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_hi_zero  = w_hi_zero & (r_scratch[4*k +: 4] == 4'd0);
            w_blank[k] = w_hi_zero;
        end
    end
`endif

    // Datapath: capture, per-step shift, and result publication in FIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank     <= c_blank_rst;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= bin;
                    end
                end
                S_LOAD: begin
                    r_scratch <= '0;
                    r_ovf     <= 1'b0;
                    r_cnt     <= c_cnt_load;
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_sh;
                    r_shift   <= w_shift_sh;
                    r_ovf     <= r_ovf | w_carry;
                    r_cnt     <= r_cnt - c_cnt_one;
                end
                S_FIN: begin
                    bcd      <= r_scratch;
                    overflow <= r_ovf;
                    done     <= 1'b1;
`ifdef BIN2BCD_BLANK_EN
                    blank    <= w_blank;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking scoreboard bench for bin2bcd_seq. Three
//               instances (8b/3d, 8b/2d, 16b/5d) are driven with directed and
//               random operands; expected results come from decimal arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
        int          stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   b0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin0 = '0, bin1 = '0;
    logic [15:0] bin2 = '0;
    logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;
    logic [2:0]  blank0;
    logic [1:0]  blank1;
    logic [4:0]  blank2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef BIN2BCD_BLANK_EN
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d0 (.clk(clk), .reset(rst), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0), .blank(blank0));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d1 (.clk(clk), .reset(rst), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1), .blank(blank1));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d2 (.clk(clk), .reset(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2), .blank(blank2));
`else
    assign blank0 = '0;
    assign blank1 = '0;
    assign blank2 = '0;
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d0 (.clk(clk), .reset(rst), .start(start0), .bin(bin0),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d1 (.clk(clk), .reset(rst), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d2 (.clk(clk), .reset(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));
`endif

    // Reference: decimal value modulo 10^digits, overflow when it does not fit
    function automatic exp_t model(input longint v, input int digits, input int stamp);
        exp_t   r;
        longint m = 1;
        longint x;
        bit     hi;
        for (int i = 0; i < digits; i++) m = m * 10;
        r.ovf   = (v >= m);
        x       = v % m;
        r.bcd   = '0;
        r.blank = '0;
        for (int i = 0; i < digits; i++) begin
            r.bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        hi = 1'b1;
        for (int k = digits - 1; k >= 1; k--) begin
            hi = hi && (r.bcd[4*k +: 4] == 4'd0);
            r.blank[k] = hi;
        end
        r.stamp = stamp;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic score(input int d, input logic [39:0] bcd, input logic ovf,
                         input logic [9:0] blk, input int lat);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d%0d unexpected_done: got done=1 expected no done (t=%0t)", d, $time);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("d%0d bcd", d), 64'(bcd), 64'(e.bcd));
            check($sformatf("d%0d overflow", d), 64'(ovf), 64'(e.ovf));
            check($sformatf("d%0d latency", d), 64'(cyc - e.stamp), 64'(lat));
`ifdef BIN2BCD_BLANK_EN
            check($sformatf("d%0d blank", d), 64'(blk), 64'(e.blank));
`else
            if (blk != 10'd0) check($sformatf("d%0d blank", d), 64'(blk), 64'd0);
`endif
        end
    endtask

    // Monitors: compare whenever a DUT presents done
    always @(negedge clk) begin
        if (rst) begin
            b0 = 0;
        end else begin
            if (busy0) b0++;
            if (done0) begin
                score(0, 40'(bcd0), ovf0, 10'(blank0), 10);
                check("d0 busy_cycles", 64'(b0), 64'd10);
                b0 = 0;
            end
        end
    end
    always @(negedge clk) if (!rst && done1) score(1, 40'(bcd1), ovf1, 10'(blank1), 10);
    always @(negedge clk) if (!rst && done2) score(2, 40'(bcd2), ovf2, 10'(blank2), 18);

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
    endfunction

    // Called at posedge+1; returns at posedge+1 with the DUT in IDLE
    task automatic wait_idle(input int d);
        for (int i = 0; i < 100; i++) begin
            if (!busy_of(d)) return;
            @(posedge clk); #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL d%0d idle_timeout: got busy=1 expected idle within 100 cycles", d);
    endtask

    task automatic go(input int d, input longint v, input bit hold);
        wait_idle(d);
        case (d)
            0:       begin start0 = 1'b1; bin0 = v[7:0];  end
            1:       begin start1 = 1'b1; bin1 = v[7:0];  end
            default: begin start2 = 1'b1; bin2 = v[15:0]; end
        endcase
        @(posedge clk); #1;
        case (d)
            0: begin
                q0.push_back(model(longint'(v[7:0]), 3, cyc));
                if (!hold) start0 = 1'b0;
                bin0 = 8'($urandom);
            end
            1: begin
                q1.push_back(model(longint'(v[7:0]), 2, cyc));
                if (!hold) start1 = 1'b0;
                bin1 = 8'($urandom);
            end
            default: begin
                q2.push_back(model(longint'(v[15:0]), 5, cyc));
                if (!hold) start2 = 1'b0;
                bin2 = 16'($urandom);
            end
        endcase
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) return;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3;
        check("reset bcd", 64'(bcd0), 64'd0);
        check("reset overflow", 64'(ovf0), 64'd0);
        check("reset done", 64'(done0), 64'd0);
        check("reset busy", 64'(busy0), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        go(0, 255, 0);
        go(0, 0, 1);              // start held high: re-trigger at return to IDLE
        wait_idle(0);
        bin0 = 8'd99;
        @(posedge clk); #1;
        q0.push_back(model(99, 3, cyc));
        start0 = 1'b0;
        go(0, 7, 0);
        go(0, 40, 0);
        go(0, 0, 0);

        go(1, 200, 0);
        go(1, 45, 0);
        go(2, 65535, 0);
        go(2, 0, 0);

        go(0, 123, 0);            // second start while busy must be ignored
        repeat (3) begin @(posedge clk); #1; end
        start0 = 1'b1; bin0 = 8'd7;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_idle(0); wait_idle(1); wait_idle(2);
        drain();

        wait_idle(0);             // aborted conversion: no expectation pushed
        start0 = 1'b1; bin0 = 8'd250;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort bcd", 64'(bcd0), 64'd0);
        check("abort overflow", 64'(ovf0), 64'd0);
        check("abort done", 64'(done0), 64'd0);
        check("abort busy", 64'(busy0), 64'd0);
        check("abort d1 bcd", 64'(bcd1), 64'd0);
`ifdef BIN2BCD_BLANK_EN
        check("abort blank", 64'(blank0), 64'b110);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        go(0, 250, 0);

        for (int i = 0; i < 20; i++) begin
            go(0, longint'($urandom_range(0, 255)), 0);
            go(1, longint'($urandom_range(0, 255)), 0);
            go(2, longint'($urandom_range(0, 65535)), 0);
        end
        wait_idle(0); wait_idle(1); wait_idle(2);
        drain();
        check("q0 empty", 64'(q0.size()), 64'd0);
        check("q1 empty", 64'(q1.size()), 64'd0);
        check("q2 empty", 64'(q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
